// File: rtl/pc_sequencer_if.sv
// Fetch-stage control bus between the control unit and the PC sequencer.
// master drives operations and operands; slave returns PC and stack status.
interface pc_sequencer_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DW    = 3
);
   logic             stall;
   logic [2:0]       op;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] offset;
   logic             cond;
   logic             clr_err;
   logic [WIDTH-1:0] pc;
   logic [DW-1:0]    depth;
   logic             full;
   logic             empty;
   logic             err_ovf;
   logic             err_unf;

   modport master (
      output stall, op, target, offset, cond, clr_err,
      input  pc, depth, full, empty, err_ovf, err_unf
   );

   modport slave (
      input  stall, op, target, offset, cond, clr_err,
      output pc, depth, full, empty, err_ovf, err_unf
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: INC/JUMP/BRANCH/CALL/RET with a return-address
// stack, stall freeze and sticky overflow/underflow flags.
module pc_sequencer #(
   parameter int unsigned     WIDTH        = 16,
   parameter int unsigned     STEP         = 1,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int unsigned     STACK_DEPTH  = 4,
   parameter int unsigned     DW           = $clog2(STACK_DEPTH + 1)
) (
   input logic           clk,
   input logic           rst_n,
   pc_sequencer_if.slave bus
);

   localparam int unsigned AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   typedef enum logic [2:0] {
      OP_INC    = 3'd0,
      OP_JUMP   = 3'd1,
      OP_BRANCH = 3'd2,
      OP_CALL   = 3'd3,
      OP_RET    = 3'd4,
      OP_HOLD   = 3'd5
   } op_e;

   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_stack [STACK_DEPTH];
   logic [DW-1:0]    r_depth;
   logic             r_full;
   logic             r_empty;
   logic             r_err_ovf;
   logic             r_err_unf;

   logic [WIDTH-1:0] w_pc_step;
   logic [WIDTH-1:0] w_pc_branch;
   logic [WIDTH-1:0] w_top;
   logic [AW-1:0]    w_wr_idx;
   logic [AW-1:0]    w_rd_idx;
   logic [WIDTH-1:0] w_pc_nxt;
   logic [DW-1:0]    w_depth_nxt;
   logic             w_push;
   logic             w_set_ovf;
   logic             w_set_unf;

   // Datapath candidates; top of stack sits at index depth-1
   always_comb begin
      w_pc_step   = r_pc + WIDTH'(STEP);
      w_pc_branch = r_pc + bus.offset;
      w_wr_idx    = AW'(r_depth);
      w_rd_idx    = AW'(r_depth - DW'(1));
      w_top       = r_stack[w_rd_idx];
   end

   // Next-state decode; stall suppresses every state change and new error
   always_comb begin
      w_pc_nxt    = r_pc;
      w_depth_nxt = r_depth;
      w_push      = 1'b0;
      w_set_ovf   = 1'b0;
      w_set_unf   = 1'b0;
      if (!bus.stall) begin
         case (bus.op)
            OP_INC:    w_pc_nxt = w_pc_step;
            OP_JUMP:   w_pc_nxt = bus.target;
            OP_BRANCH: w_pc_nxt = bus.cond ? w_pc_branch : w_pc_step;
            OP_CALL: begin
               if (r_full) begin
                  w_set_ovf = 1'b1;
               end else begin
                  w_push      = 1'b1;
                  w_pc_nxt    = bus.target;
                  w_depth_nxt = r_depth + DW'(1);
               end
            end
            OP_RET: begin
               if (r_empty) begin
                  w_set_unf = 1'b1;
               end else begin
                  w_pc_nxt    = w_top;
                  w_depth_nxt = r_depth - DW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Control state; full/empty registered alongside depth
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc      <= RESET_VECTOR;
         r_depth   <= '0;
         r_full    <= 1'b0;
         r_empty   <= 1'b1;
         r_err_ovf <= 1'b0;
         r_err_unf <= 1'b0;
      end else begin
         r_pc      <= w_pc_nxt;
         r_depth   <= w_depth_nxt;
         r_full    <= (w_depth_nxt == DW'(STACK_DEPTH));
         r_empty   <= (w_depth_nxt == '0);
         r_err_ovf <= w_set_ovf | (r_err_ovf & ~bus.clr_err);
         r_err_unf <= w_set_unf | (r_err_unf & ~bus.clr_err);
      end
   end

   // Stack storage needs no reset: entries above depth are never read
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_stack[w_wr_idx] <= w_pc_step;
      end
   end

   assign bus.pc      = r_pc;
   assign bus.depth   = r_depth;
   assign bus.full    = r_full;
   assign bus.empty   = r_empty;
   assign bus.err_ovf = r_err_ovf;
   assign bus.err_unf = r_err_unf;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer replacing the bare 16-bit PC register in the fetch stage. It holds the current instruction address and, each clock, applies one of several next-PC operations: increment, absolute jump, conditional relative branch, call and return. Call/return use an internal return-address stack of configurable depth. A stall input freezes the sequencer, and sticky error flags report stack overflow and underflow to the control unit.

## Interface
- WIDTH, 16: address width in bits.
- STEP, 1: increment applied by INC and used for the CALL return address.
- RESET_VECTOR, 0: PC value after reset.
- STACK_DEPTH, 4: number of return-address entries; must be at least 1.
- DW, $clog2(STACK_DEPTH+1): width of the `depth` output.

Ports (the `depth` port width is given by DW):
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  when 1, pc and stack state hold and op is ignored.
- op  in  3  operation: 0 INC, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5 HOLD, 6/7 reserved (treated as HOLD).
- target  in  WIDTH  absolute destination for JUMP and CALL.
- offset  in  WIDTH  two's-complement displacement for BRANCH.
- cond  in  1  BRANCH is taken when 1.
- clr_err  in  1  clears err_ovf and err_unf.
- pc  out  WIDTH  current PC (registered).
- depth  out  DW  number of valid stack entries (registered).
- full  out  1  depth == STACK_DEPTH.
- empty  out  1  depth == 0.
- err_ovf  out  1  sticky: a CALL was attempted with the stack full.
- err_unf  out  1  sticky: a RET was attempted with the stack empty.

## Operation
- Reset (rst_n=0, asynchronous): pc=RESET_VECTOR, depth=0, empty=1, full=0, err_ovf=0, err_unf=0. Stack contents are don't-care.
- Operations when stall=0, per rising edge:
  - INC: pc <= pc+STEP.
  - JUMP: pc <= target.
  - BRANCH: if cond=1, pc <= pc+offset; if cond=0, pc <= pc+STEP.
  - CALL, stack not full: push pc+STEP, then pc <= target, depth+1.
  - CALL, stack full: pc and stack unchanged; err_ovf <= 1.
  - RET, stack not empty: pc <= top entry (pop), depth-1.
  - RET, stack empty: pc unchanged; err_unf <= 1.
  - HOLD/reserved: no change.
- Arithmetic is modulo 2^WIDTH: pc+STEP and pc+offset wrap silently with no flag. Example: pc=16'hFFFF, INC gives 16'h0000.
- Stack is LIFO. Entry index depth-1 is the top. There is no circular wrap: overflow drops the CALL entirely, with no overwrite.
- stall=1: pc, stack and depth hold; op, target, offset and cond are ignored; no new error flags are set.
- clr_err is independent of stall. If clr_err=1 and a new error occurs on the same edge, the flag ends at 1 (set wins).
- err flags stay at 1 until clr_err or reset.
- full and empty are derived from the registered depth, so they are stable for the whole cycle.

## Timing
- Single-cycle latency: op and its operands are sampled at edge N; the new pc is visible after edge N. Fetch uses pc during cycle N+1.
- Every output is registered or a pure function of registers; there is no combinational path from any input to any output.
- Back-to-back CALL/RET on consecutive cycles is supported at full rate. A RET on the cycle after a CALL returns the address just pushed.
- Reset asserted mid-operation forces the reset values immediately, regardless of clk. The first operation after deassertion is sampled on the first rising edge with rst_n=1.
- Error flags update on the same edge as the offending op.

## Test plan
Default parameters unless stated (WIDTH=16, STEP=1, RESET_VECTOR=0); STACK_DEPTH=2 where noted.
- Reset then 3× INC, then JUMP target=16'h0100, then INC: pc sequence 0,1,2,3,16'h0100,16'h0101; depth=0, empty=1 throughout.
- pc=16'h0010; BRANCH offset=16'hFFF8, cond=1 -> pc=16'h0008. BRANCH cond=0 -> pc=16'h0009. pc=16'hFFFF with INC -> 16'h0000.
- STACK_DEPTH=2; pc=5:
  - CALL target=16'h40 -> pc=16'h40, depth=1.
  - CALL target=16'h80 -> pc=16'h80, depth=2, full=1.
  - Third CALL -> pc stays 16'h80, err_ovf=1.
  - RET -> pc=16'h41. RET -> pc=6, empty=1.
  - Third RET -> pc=6, err_unf=1.
- stall=1 held 3 cycles with op=CALL, target=16'h200: pc, depth and flags unchanged. With stall=1 and clr_err=1: both errors clear.
- Same-edge clr_err=1 with CALL while full -> err_ovf=1 after the edge.
- rst_n pulsed low between clock edges with depth=2 and pc=16'h80: pc=0, depth=0 and error flags=0 immediately, before the next edge.
